// File: rtl/tlb_pkg.sv
// Shared definitions for the CP0 TLB instruction sequencer:
// op codes, default TLB geometry, FSM state encoding and Index layout.
package tlb_pkg;

    localparam int TLB_LINE_DEFAULT  = 32;
    localparam int TLB_WIDTH_DEFAULT = 5;

    // TLB op codes as decoded in the M stage and driven on tlb_type
    localparam logic [2:0] OP_NONE  = 3'b000;
    localparam logic [2:0] OP_TLBP  = 3'b001;
    localparam logic [2:0] OP_TLBR  = 3'b010;
    localparam logic [2:0] OP_TLBWI = 3'b011;
    localparam logic [2:0] OP_TLBWR = 3'b100;

    // Index[31] is the probe-fail flag; the TLB sets it on a TLBP miss
    localparam int INDEX_P_BIT = 31;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } tlb_state_e;

    function automatic logic op_is_legal(input logic [2:0] op);
        return (op == OP_TLBP) || (op == OP_TLBR) ||
               (op == OP_TLBWI) || (op == OP_TLBWR);
    endfunction

endpackage

// File: rtl/tlb_random_ctr.sv
// CP0 Random register: free-running down-counter that wraps to the top
// entry once it reaches the Wired boundary, so TLBWR never lands in a
// wired slot.
module tlb_random_ctr
    import tlb_pkg::*;
#(
    parameter int TLB_LINE  = TLB_LINE_DEFAULT,
    parameter int TLB_WIDTH = TLB_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [4:0]           wired,
    input  logic                 wired_we,
    output logic [TLB_WIDTH-1:0] random
);

    localparam logic [TLB_WIDTH-1:0] RND_MAX = TLB_WIDTH'(TLB_LINE - 1);

    logic [TLB_WIDTH-1:0] rnd_q, rnd_d;

    // A Wired write or reaching the Wired boundary restarts from the top;
    // Wired >= TLB_LINE-1 therefore pins the counter at the top entry.
    always_comb begin
        rnd_d = rnd_q - 1'b1;
        if (wired_we || (rnd_q <= wired)) begin
            rnd_d = RND_MAX;
        end
    end

    // Random register, reset to the top entry
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rnd_q <= RND_MAX;
        end else begin
            rnd_q <= rnd_d;
        end
    end

    assign random = rnd_q;

endmodule

// File: rtl/tlb_op_seq.sv
// M-stage sequencer for TLBP/TLBR/TLBWI/TLBWR: stalls the pipeline for the
// op, strobes the TLB for exactly one cycle and turns probe/read results
// into CP0 write-back strobes.
//
// Handshake: op_valid with a legal op_type is taken in IDLE in the same
// cycle it is presented; stall is the "not ready" answer and holds M and
// earlier stages until WB, when done pulses and M advances. The op must
// stay presented while stall is high only in the accept cycle; after that
// the op is latched internally.
module tlb_op_seq
    import tlb_pkg::*;
#(
    parameter int TLB_LINE  = TLB_LINE_DEFAULT,
    parameter int TLB_WIDTH = TLB_WIDTH_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        op_valid,
    input  logic [2:0]  op_type,
    input  logic        flush,
    input  logic [4:0]  wired,
    input  logic        wired_we,
    input  logic [31:0] index_res,
    input  logic [31:0] entryhi_res,
    input  logic [31:0] pagemask_res,
    input  logic [31:0] entrylo0_res,
    input  logic [31:0] entrylo1_res,
    output logic [2:0]  tlb_type,
    output logic        stall,
    output logic        done,
    output logic        cp0_we_index,
    output logic [31:0] cp0_index_wdata,
    output logic        cp0_we_tlbr,
    output logic [31:0] cp0_entryhi_wdata,
    output logic [31:0] cp0_pagemask_wdata,
    output logic [31:0] cp0_entrylo0_wdata,
    output logic [31:0] cp0_entrylo1_wdata,
    output logic        refetch,
    output logic [31:0] random,
    output logic [1:0]  state_dbg
);

    tlb_state_e  state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] index_q, index_d;
    logic [31:0] entryhi_q, entryhi_d;
    logic [31:0] pagemask_q, pagemask_d;
    logic [31:0] entrylo0_q, entrylo0_d;
    logic [31:0] entrylo1_q, entrylo1_d;
    logic        accept;
    logic        capture;
    logic [TLB_WIDTH-1:0] rnd;

    // resetn gates accept so stall stays low while reset is held
    assign accept  = resetn && (state_q == S_IDLE) && op_valid &&
                     op_is_legal(op_type) && !flush;
    assign capture = (state_q == S_EXEC) && !flush;

    // Next state and latched op; a flush in EXEC abandons the op
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_EXEC;
                    op_d    = op_type;
                end
            end
            S_EXEC:  state_d = flush ? S_IDLE : S_WB;
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Result capture at the edge ending EXEC; values hold outside of it
    always_comb begin
        index_d    = index_q;
        entryhi_d  = entryhi_q;
        pagemask_d = pagemask_q;
        entrylo0_d = entrylo0_q;
        entrylo1_d = entrylo1_q;
        if (capture && (op_q == OP_TLBP)) begin
            index_d = index_res;
        end
        if (capture && (op_q == OP_TLBR)) begin
            entryhi_d  = entryhi_res;
            pagemask_d = pagemask_res;
            entrylo0_d = entrylo0_res;
            entrylo1_d = entrylo1_res;
        end
    end

    // Strobes decoded from state; flush kills the TLB strobe in EXEC and
    // the refetch in WB (the flush owns the redirect there)
    always_comb begin
        tlb_type     = OP_NONE;
        stall        = 1'b0;
        done         = 1'b0;
        cp0_we_index = 1'b0;
        cp0_we_tlbr  = 1'b0;
        refetch      = 1'b0;
        case (state_q)
            S_IDLE: stall = accept;
            S_EXEC: begin
                stall = 1'b1;
                if (!flush) begin
                    tlb_type = op_q;
                end
            end
            S_WB: begin
                done         = 1'b1;
                cp0_we_index = (op_q == OP_TLBP);
                cp0_we_tlbr  = (op_q == OP_TLBR);
                refetch      = !flush && (op_q != OP_TLBP);
            end
            default: ;
        endcase
    end

    // FSM and capture registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            op_q       <= OP_NONE;
            index_q    <= '0;
            entryhi_q  <= '0;
            pagemask_q <= '0;
            entrylo0_q <= '0;
            entrylo1_q <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            index_q    <= index_d;
            entryhi_q  <= entryhi_d;
            pagemask_q <= pagemask_d;
            entrylo0_q <= entrylo0_d;
            entrylo1_q <= entrylo1_d;
        end
    end

    tlb_random_ctr #(
        .TLB_LINE  (TLB_LINE),
        .TLB_WIDTH (TLB_WIDTH)
    ) u_random (
        .clk      (clk),
        .resetn   (resetn),
        .wired    (wired),
        .wired_we (wired_we),
        .random   (rnd)
    );

    assign cp0_index_wdata    = index_q;
    assign cp0_entryhi_wdata  = entryhi_q;
    assign cp0_pagemask_wdata = pagemask_q;
    assign cp0_entrylo0_wdata = entrylo0_q;
    assign cp0_entrylo1_wdata = entrylo1_q;
    assign random             = {{(32-TLB_WIDTH){1'b0}}, rnd};
    assign state_dbg          = state_q;

endmodule

// File: tb/tb_tlb_op_seq.sv
// Directed bench for tlb_op_seq: expected write-back records are queued
// when an op is issued and popped when done pulses.
module tb_tlb_op_seq;
    import tlb_pkg::*;

    localparam int W = 3 + 5 * 32;

    logic        clk;
    logic        resetn;
    logic        op_valid;
    logic [2:0]  op_type;
    logic        flush;
    logic [4:0]  wired;
    logic        wired_we;
    logic [31:0] index_res, entryhi_res, pagemask_res, entrylo0_res, entrylo1_res;
    logic [2:0]  tlb_type;
    logic        stall, done, cp0_we_index, cp0_we_tlbr, refetch;
    logic [31:0] cp0_index_wdata, cp0_entryhi_wdata, cp0_pagemask_wdata;
    logic [31:0] cp0_entrylo0_wdata, cp0_entrylo1_wdata, random;
    logic [1:0]  state_dbg;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] exp_q[$];
    logic [31:0]  m_idx = '0, m_eh = '0, m_pm = '0, m_lo0 = '0, m_lo1 = '0;
    logic [4:0]   mdl_rnd;

    tlb_op_seq dut (
        .clk                (clk),
        .resetn             (resetn),
        .op_valid           (op_valid),
        .op_type            (op_type),
        .flush              (flush),
        .wired              (wired),
        .wired_we           (wired_we),
        .index_res          (index_res),
        .entryhi_res        (entryhi_res),
        .pagemask_res       (pagemask_res),
        .entrylo0_res       (entrylo0_res),
        .entrylo1_res       (entrylo1_res),
        .tlb_type           (tlb_type),
        .stall              (stall),
        .done               (done),
        .cp0_we_index       (cp0_we_index),
        .cp0_index_wdata    (cp0_index_wdata),
        .cp0_we_tlbr        (cp0_we_tlbr),
        .cp0_entryhi_wdata  (cp0_entryhi_wdata),
        .cp0_pagemask_wdata (cp0_pagemask_wdata),
        .cp0_entrylo0_wdata (cp0_entrylo0_wdata),
        .cp0_entrylo1_wdata (cp0_entrylo1_wdata),
        .refetch            (refetch),
        .random             (random),
        .state_dbg          (state_dbg)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Reference Random register
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mdl_rnd <= 5'd31;
        end else if (wired_we || (mdl_rnd <= wired)) begin
            mdl_rnd <= 5'd31;
        end else begin
            mdl_rnd <= mdl_rnd - 5'd1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: compare write-back strobes and data whenever done pulses
    always @(negedge clk) begin
        if (resetn && done) begin
            logic [W-1:0] obs;
            logic [W-1:0] exp;
            obs = {cp0_we_index, cp0_we_tlbr, refetch, cp0_index_wdata,
                   cp0_entryhi_wdata, cp0_pagemask_wdata,
                   cp0_entrylo0_wdata, cp0_entrylo1_wdata};
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $error("FAIL wb_unexpected observed=%h expected=none", obs);
            end else begin
                exp = exp_q.pop_front();
                assert (obs === exp) else begin
                    n_fail++;
                    $error("FAIL wb_record observed=%h expected=%h", obs, exp);
                end
            end
        end else if (resetn) begin
            chk("strobes_idle", {29'd0, cp0_we_index, cp0_we_tlbr, refetch}, 32'd0);
        end
    end

    // Issue one op through IDLE, EXEC and WB with optional flushes
    task automatic run_op(input logic [2:0] op, input logic fl_exec, input logic fl_wb,
                          input logic [31:0] idx, input logic [31:0] eh,
                          input logic [31:0] pm, input logic [31:0] lo0,
                          input logic [31:0] lo1);
        @(posedge clk); #1;
        op_valid     = 1'b1;
        op_type      = op;
        index_res    = idx;
        entryhi_res  = eh;
        pagemask_res = pm;
        entrylo0_res = lo0;
        entrylo1_res = lo1;
        if (!fl_exec) begin
            if (op == OP_TLBP) m_idx = idx;
            if (op == OP_TLBR) begin
                m_eh = eh; m_pm = pm; m_lo0 = lo0; m_lo1 = lo1;
            end
            exp_q.push_back({op == OP_TLBP, op == OP_TLBR, (op != OP_TLBP) && !fl_wb,
                             m_idx, m_eh, m_pm, m_lo0, m_lo1});
        end
        @(negedge clk);
        chk("c0_stall", {31'd0, stall}, 32'd1);
        chk("c0_tlb_type", {29'd0, tlb_type}, 32'd0);
        chk("c0_state", {30'd0, state_dbg}, {30'd0, S_IDLE});
        @(posedge clk); #1;
        op_valid = 1'b0;
        op_type  = 3'b000;
        flush    = fl_exec;
        @(negedge clk);
        chk("c1_stall", {31'd0, stall}, 32'd1);
        chk("c1_tlb_type", {29'd0, tlb_type}, fl_exec ? 32'd0 : {29'd0, op});
        chk("c1_state", {30'd0, state_dbg}, {30'd0, S_EXEC});
        if (op == OP_TLBWR) chk("c1_wr_slot", random, {27'd0, mdl_rnd});
        @(posedge clk); #1;
        flush = fl_exec ? 1'b0 : fl_wb;
        @(negedge clk);
        chk("c2_stall", {31'd0, stall}, 32'd0);
        chk("c2_done", {31'd0, done}, fl_exec ? 32'd0 : 32'd1);
        chk("c2_tlb_type", {29'd0, tlb_type}, 32'd0);
        chk("c2_state", {30'd0, state_dbg}, fl_exec ? {30'd0, S_IDLE} : {30'd0, S_WB});
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; op_valid = 1'b0; op_type = 3'b000; flush = 1'b0;
        wired = 5'd4; wired_we = 1'b0;
        index_res = '0; entryhi_res = '0; pagemask_res = '0;
        entrylo0_res = '0; entrylo1_res = '0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tlb_type", {29'd0, tlb_type}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_we", {29'd0, cp0_we_index, cp0_we_tlbr, refetch}, 32'd0);
        chk("rst_wdata", cp0_index_wdata | cp0_entryhi_wdata | cp0_pagemask_wdata |
                         cp0_entrylo0_wdata | cp0_entrylo1_wdata, 32'd0);
        chk("rst_random", random, 32'd31);

        // Random wrap against Wired=4, then a Wired write at 20
        @(posedge clk); #1;
        resetn = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            chk("rnd_seq", random, (k <= 27) ? 32'(31 - k) : 32'(59 - k));
        end
        wired_we = 1'b1;
        @(posedge clk); #1;
        wired_we = 1'b0;
        @(negedge clk);
        chk("rnd_wired_we", random, 32'd31);

        // TLBP hit, TLBP miss, TLBR
        run_op(OP_TLBP, 1'b0, 1'b0, 32'h0000000A, 32'h1, 32'h2, 32'h3, 32'h4);
        run_op(OP_TLBP, 1'b0, 1'b0, 32'h80000000, 32'h5, 32'h6, 32'h7, 32'h8);
        run_op(OP_TLBR, 1'b0, 1'b0, 32'h00000011, 32'h12345000, 32'h00006000,
               32'h00000047, 32'h00000087);
        @(negedge clk);
        chk("index_hold", cp0_index_wdata, 32'h80000000);
        chk("entryhi_hold", cp0_entryhi_wdata, 32'h12345000);

        // TLBWR shows its slot on random during EXEC
        run_op(OP_TLBWR, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);

        // Flush in EXEC of TLBWI, then a normal TLBWI
        run_op(OP_TLBWI, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        run_op(OP_TLBWI, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);

        // Flush in WB: done still fires, refetch suppressed
        run_op(OP_TLBR, 1'b0, 1'b1, 32'h0, 32'hABCDE000, 32'h0001E000,
               32'h00000017, 32'h00000027);
        run_op(OP_TLBP, 1'b0, 1'b1, 32'h0000001F, 32'h0, 32'h0, 32'h0, 32'h0);

        // Illegal op type and flush in IDLE are not accepted
        op_valid = 1'b1; op_type = 3'b111;
        @(negedge clk);
        chk("illegal_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        op_type = OP_TLBWI; flush = 1'b1;
        @(negedge clk);
        chk("illegal_state", {30'd0, state_dbg}, {30'd0, S_IDLE});
        chk("idle_flush_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        op_valid = 1'b0; op_type = 3'b000; flush = 1'b0;
        @(negedge clk);
        chk("idle_flush_state", {30'd0, state_dbg}, {30'd0, S_IDLE});

        // Reset during EXEC
        @(posedge clk); #1;
        op_valid = 1'b1; op_type = OP_TLBWI;
        @(posedge clk); #1;
        op_valid = 1'b0; op_type = 3'b000;
        @(negedge clk);
        chk("mid_exec_type", {29'd0, tlb_type}, {29'd0, OP_TLBWI});
        resetn = 1'b0;
        #1;
        chk("mid_rst_stall", {31'd0, stall}, 32'd0);
        chk("mid_rst_tlb_type", {29'd0, tlb_type}, 32'd0);
        chk("mid_rst_random", random, 32'd31);
        chk("mid_rst_state", {30'd0, state_dbg}, {30'd0, S_IDLE});
        @(posedge clk); #1;
        resetn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_rst_done", {31'd0, done}, 32'd0);
            chk("post_rst_stall", {31'd0, stall}, 32'd0);
            chk("post_rst_tlb_type", {29'd0, tlb_type}, 32'd0);
        end

        // Every queued write-back must have been seen
        chk("sb_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
